// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed scan of an 8-digit seven-segment display.
// Each digit slot is a dark BLANK interval followed by a lit SHOW interval;
// the digit value and its enable bit are captured once at the BLANK->SHOW
// edge, so input changes mid-slot never disturb the lit digit.
module hex_scan_driver #(
    parameter int SHOW_CYCLES  = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic [3:0] hex0_i,
    input  logic [3:0] hex1_i,
    input  logic [3:0] hex2_i,
    input  logic [3:0] hex3_i,
    input  logic [3:0] hex4_i,
    input  logic [3:0] hex5_i,
    input  logic [3:0] hex6_i,
    input  logic [3:0] hex7_i,
    input  logic [7:0] bitmask_i,
    output logic [6:0] hex_led_o,
    output logic [7:0] hex_sel_o,
    output logic       frame_tick_o
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [6:0]    LED_DARK   = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    dig_q, dig_d;
    logic          en_q, en_d;
    logic [6:0]    led_q, led_d;
    logic [7:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic [3:0]    cur_hex;

    // Active-high abcdefg pattern, bit0 = segment a.
    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Select the digit register for the slot currently being scanned.
    always_comb begin
        cur_hex = hex0_i;
        case (idx_q)
            3'd0: cur_hex = hex0_i;
            3'd1: cur_hex = hex1_i;
            3'd2: cur_hex = hex2_i;
            3'd3: cur_hex = hex3_i;
            3'd4: cur_hex = hex4_i;
            3'd5: cur_hex = hex5_i;
            3'd6: cur_hex = hex6_i;
            default: cur_hex = hex7_i;
        endcase
    end

    // Next-state and registered-output logic for the BLANK/SHOW slot sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        dig_d   = dig_q;
        en_d    = en_q;
        led_d   = LED_DARK;
        sel_d   = 8'h00;
        tick_d  = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                    dig_d   = cur_hex;
                    en_d    = bitmask_i[idx_q];
                    // Outputs light at the same edge the digit is captured.
                    if (bitmask_i[idx_q]) begin
                        sel_d = 8'd1 << idx_q;
                        led_d = ~seg(cur_hex);
                    end
                end
            end
            default: begin
                if (en_q) begin
                    sel_d = 8'd1 << idx_q;
                    led_d = ~seg(dig_q);
                end
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 3'd1;
                    sel_d   = 8'h00;
                    led_d   = LED_DARK;
                    tick_d  = (idx_q == 3'd7);
                end
            end
        endcase
    end

    // State, counter, captured digit and output registers.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            dig_q   <= 4'd0;
            en_q    <= 1'b0;
            led_q   <= LED_DARK;
            sel_q   <= 8'h00;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            en_q    <= en_d;
            led_q   <= led_d;
            sel_q   <= sel_d;
            tick_q  <= tick_d;
        end
    end

    assign hex_led_o    = led_q;
    assign hex_sel_o    = sel_q;
    assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver with SHOW_CYCLES=4, BLANK_CYCLES=2. The reference
// model derives every output from the number of edges since reset: slot
// position by division/modulo, digit captured at the first lit cycle.
module tb_hex_scan_driver;

    localparam int SHOW  = 4;
    localparam int BLANK = 2;
    localparam int P     = SHOW + BLANK;
    localparam int FRAME = 8 * P;

    logic       clk_i = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hex_v [8];
    logic [7:0] bitmask_i = 8'h00;
    logic [6:0] hex_led_o;
    logic [7:0] hex_sel_o;
    logic       frame_tick_o;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         k = 0;
    logic [3:0] cap_dig = 4'h0;
    logic       cap_en = 1'b0;
    logic       exp_lit;
    logic [7:0] exp_sel;
    logic [6:0] exp_led;
    logic       exp_tick;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    hex_scan_driver #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLANK)) dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .hex0_i      (hex_v[0]),
        .hex1_i      (hex_v[1]),
        .hex2_i      (hex_v[2]),
        .hex3_i      (hex_v[3]),
        .hex4_i      (hex_v[4]),
        .hex5_i      (hex_v[5]),
        .hex6_i      (hex_v[6]),
        .hex7_i      (hex_v[7]),
        .bitmask_i   (bitmask_i),
        .hex_led_o   (hex_led_o),
        .hex_sel_o   (hex_sel_o),
        .frame_tick_o(frame_tick_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock, update the model, and land on the following negedge.
    task automatic step();
        int d;
        @(posedge clk_i);
        if (rst) k = 0;
        else k = k + 1;
        d = (k / P) % 8;
        if (!rst && (k % P) == BLANK) begin
            cap_dig = hex_v[d];
            cap_en  = bitmask_i[d];
        end
        exp_lit  = ((k % P) >= BLANK) && cap_en;
        exp_sel  = exp_lit ? 8'(1 << d) : 8'h00;
        exp_led  = exp_lit ? ~seg_tab[cap_dig] : 7'h7F;
        exp_tick = (k > 0) && ((k % FRAME) == 0);
        @(negedge clk_i);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) hex_v[i] = 4'(i);
        bitmask_i = 8'hFF;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (hex_sel_o !== 8'h00 || hex_led_o !== 7'h7F || frame_tick_o !== 1'b0) begin
            errors++;
            $display("FAIL reset sel=%h led=%h tick=%b, want sel=00 led=7f tick=0",
                     hex_sel_o, hex_led_o, frame_tick_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_digit();
        hex_v[0] = 4'h8;
        bitmask_i = 8'hFF;
        reset_dut();
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led || frame_tick_o !== exp_tick) begin
                errors++;
                $display("FAIL single k=%0d sel=%h led=%h tick=%b, want %h %h %b",
                         k, hex_sel_o, hex_led_o, frame_tick_o, exp_sel, exp_led, exp_tick);
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if (hex_sel_o !== 8'h01 || hex_led_o !== 7'h00) begin
                    errors++;
                    $display("FAIL single_lit k=%0d sel=%h led=%h, want 01 00", k, hex_sel_o, hex_led_o);
                end
            end
        end
    endtask

    task automatic test_walk();
        logic [6:0] walk_led [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        int ticks = 0;
        int tick_k = -1;
        for (int i = 0; i < 8; i++) hex_v[i] = 4'(i);
        bitmask_i = 8'hFF;
        reset_dut();
        for (int c = 1; c <= 50; c++) begin
            step();
            if (frame_tick_o === 1'b1) begin
                ticks++;
                tick_k = k;
            end
            checks++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led || frame_tick_o !== exp_tick) begin
                errors++;
                $display("FAIL walk k=%0d sel=%h led=%h tick=%b, want %h %h %b",
                         k, hex_sel_o, hex_led_o, frame_tick_o, exp_sel, exp_led, exp_tick);
            end
            if ((k % P) == BLANK + 1) begin
                checks++;
                if (hex_led_o !== walk_led[k / P]) begin
                    errors++;
                    $display("FAIL walk_led slot=%0d led=%h, want %h", k / P, hex_led_o, walk_led[k / P]);
                end
            end
        end
        checks++;
        if (ticks != 1 || tick_k != FRAME) begin
            errors++;
            $display("FAIL walk_tick count=%0d at=%0d, want 1 at %0d", ticks, tick_k, FRAME);
        end
    endtask

    task automatic test_mask();
        for (int i = 0; i < 8; i++) hex_v[i] = 4'($urandom_range(0, 15));
        bitmask_i = 8'hA5;
        reset_dut();
        for (int c = 1; c <= FRAME + 2; c++) begin
            step();
            checks++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led || frame_tick_o !== exp_tick) begin
                errors++;
                $display("FAIL mask k=%0d sel=%h led=%h tick=%b, want %h %h %b",
                         k, hex_sel_o, hex_led_o, frame_tick_o, exp_sel, exp_led, exp_tick);
            end
            checks++;
            if ((hex_sel_o & ~8'hA5) !== 8'h00) begin
                errors++;
                $display("FAIL mask_sel k=%0d sel=%h, want subset of a5", k, hex_sel_o);
            end
        end
    endtask

    task automatic test_midslot_change();
        for (int i = 0; i < 8; i++) hex_v[i] = 4'(i);
        hex_v[0] = 4'h1;
        bitmask_i = 8'hFF;
        reset_dut();
        for (int c = 1; c <= FRAME + 4; c++) begin
            step();
            if (k == 3) hex_v[0] = 4'hF;
            checks++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led || frame_tick_o !== exp_tick) begin
                errors++;
                $display("FAIL midslot k=%0d sel=%h led=%h tick=%b, want %h %h %b",
                         k, hex_sel_o, hex_led_o, frame_tick_o, exp_sel, exp_led, exp_tick);
            end
            if (k == 5 || k == FRAME + 2) begin
                checks++;
                if (hex_led_o !== ((k == 5) ? 7'h79 : 7'h0E)) begin
                    errors++;
                    $display("FAIL midslot_led k=%0d led=%h, want %h", k, hex_led_o,
                             (k == 5) ? 7'h79 : 7'h0E);
                end
            end
        end
    endtask

    task automatic test_reset_mid_show();
        for (int i = 0; i < 8; i++) hex_v[i] = 4'(i);
        bitmask_i = 8'hFF;
        reset_dut();
        while (k < 5 * P + BLANK + 2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (hex_sel_o !== 8'h00 || hex_led_o !== 7'h7F) begin
            errors++;
            $display("FAIL rst_mid sel=%h led=%h, want 00 7f", hex_sel_o, hex_led_o);
        end
        for (int c = 1; c <= 8; c++) begin
            step();
            checks++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led || frame_tick_o !== exp_tick) begin
                errors++;
                $display("FAIL rst_after k=%0d sel=%h led=%h tick=%b, want %h %h %b",
                         k, hex_sel_o, hex_led_o, frame_tick_o, exp_sel, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_random_frames();
        int last_tick = 0;
        int nticks = 0;
        for (int i = 0; i < 8; i++) hex_v[i] = 4'($urandom_range(0, 15));
        bitmask_i = 8'($urandom_range(0, 255));
        reset_dut();
        for (int c = 1; c <= 3 * FRAME + 2; c++) begin
            step();
            checks++;
            if (hex_sel_o !== exp_sel || hex_led_o !== exp_led || frame_tick_o !== exp_tick) begin
                errors++;
                $display("FAIL random k=%0d sel=%h led=%h tick=%b, want %h %h %b",
                         k, hex_sel_o, hex_led_o, frame_tick_o, exp_sel, exp_led, exp_tick);
            end
            checks++;
            if (!$onehot0(hex_sel_o) || (hex_sel_o != 8'h00 && (k % P) < BLANK)) begin
                errors++;
                $display("FAIL sel_onehot k=%0d sel=%h, want onehot0 and dark in blank", k, hex_sel_o);
            end
            if (frame_tick_o === 1'b1) begin
                nticks++;
                checks++;
                if (k - last_tick != FRAME) begin
                    errors++;
                    $display("FAIL frame_period got=%0d want=%0d", k - last_tick, FRAME);
                end
                last_tick = k;
            end
            if ($urandom_range(0, 3) == 0) hex_v[$urandom_range(0, 7)] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) bitmask_i = 8'($urandom_range(0, 255));
        end
        checks++;
        if (nticks != 3) begin
            errors++;
            $display("FAIL frame_count got=%0d want=3", nticks);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hex_v[i] = 4'h0;
        test_reset();
        test_single_digit();
        test_walk();
        test_mask();
        test_midslot_change();
        test_reset_mid_show();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
